// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin sharing of one APB4 completer among NUM_MST requesters
module apb_rr_arbiter #(
  parameter int NUM_MST = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 0,
  localparam int GW = NUM_MST > 1 ? $clog2(NUM_MST) : 1,
  localparam int SW = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_MST-1:0]    m_psel,
  input  logic [NUM_MST-1:0]    m_penable,
  input  logic [NUM_MST-1:0]    m_pwrite,
  input  logic [NUM_MST*ADDR_W-1:0] m_paddr,
  input  logic [NUM_MST*DATA_W-1:0] m_pwdata,
  input  logic [NUM_MST*SW-1:0] m_pstrb,
  input  logic [NUM_MST*3-1:0]  m_pprot,
  output logic [DATA_W-1:0]     m_prdata,
  output logic [NUM_MST-1:0]    m_pready,
  output logic [NUM_MST-1:0]    m_pslverr,
  output logic                  s_psel,
  output logic                  s_penable,
  output logic                  s_pwrite,
  output logic [ADDR_W-1:0]     s_paddr,
  output logic [DATA_W-1:0]     s_pwdata,
  output logic [SW-1:0]         s_pstrb,
  output logic [2:0]            s_pprot,
  input  logic [DATA_W-1:0]     s_prdata,
  input  logic                  s_pready,
  input  logic                  s_pslverr,
  output logic                  busy,
  output logic [GW-1:0]         grant_idx
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] ptr_q, grant_q, off, win;
  logic [GW:0] sum;
  logic [NUM_MST-1:0] rot;
  logic [CW-1:0] wd_q;
  logic pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [SW-1:0] pstrb_q;
  logic [2:0] pprot_q;
  logic expire, done, fin, penable_unused;
  logic [ADDR_W-1:0] addr_a [NUM_MST];
  logic [DATA_W-1:0] wdata_a [NUM_MST];
  logic [SW-1:0] strb_a [NUM_MST];
  logic [2:0] prot_a [NUM_MST];
  for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
    assign addr_a[i] = m_paddr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = m_pwdata[i*DATA_W +: DATA_W];
    assign strb_a[i] = m_pstrb[i*SW +: SW];
    assign prot_a[i] = m_pprot[i*3 +: 3];
  end
  assign penable_unused = ^m_penable;
  assign rot = NUM_MST'({m_psel, m_psel} >> ptr_q);
  always_comb begin
    off = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) if (rot[k]) off = GW'(k);
  end
  assign sum = {1'b0, ptr_q} + {1'b0, off};
  assign win = sum >= (GW+1)'(NUM_MST) ? GW'(sum - (GW+1)'(NUM_MST)) : GW'(sum);
  assign expire = TIMEOUT > 0 && wd_q == CW'(TIMEOUT - 1) && !s_pready;
  assign done = state_q == ACCESS && (s_pready || expire) && !rst;
  assign fin = done && m_psel[grant_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      wd_q <= '0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      pprot_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |m_psel) begin
        grant_q <= win;
        pwrite_q <= m_pwrite[win];
        paddr_q <= addr_a[win];
        pwdata_q <= wdata_a[win];
        pstrb_q <= strb_a[win];
        pprot_q <= prot_a[win];
      end
      if (done) ptr_q <= grant_q == GW'(NUM_MST - 1) ? '0 : grant_q + GW'(1);
      wd_q <= state_q == ACCESS ? wd_q + CW'(!s_pready) : '0;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (|m_psel ? SETUP : IDLE) :
              state_q == SETUP ? ACCESS : (done ? IDLE : ACCESS);
  end
  always_comb begin
    m_pready = '0;
    m_pslverr = '0;
    m_pready[grant_q] = fin;
    m_pslverr[grant_q] = fin && (expire || s_pslverr);
    m_prdata = fin && !expire ? s_prdata : '0;
  end
  assign s_psel = state_q != IDLE;
  assign s_penable = state_q == ACCESS;
  assign busy = state_q != IDLE;
  assign grant_idx = grant_q;
  assign s_pwrite = pwrite_q;
  assign s_paddr = paddr_q;
  assign s_pwdata = pwdata_q;
  assign s_pstrb = pstrb_q;
  assign s_pprot = pprot_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: vector table, directed corner cases and a randomized model check
module tb_apb_rr_arbiter;
  localparam int N = 3, AW = 32, DW = 32, TO = 8;
  logic clk = 1'b0, rst;
  logic [N-1:0] m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [N*AW-1:0] m_paddr;
  logic [N*DW-1:0] m_pwdata;
  logic [N*4-1:0] m_pstrb;
  logic [N*3-1:0] m_pprot;
  logic [DW-1:0] m_prdata, s_pwdata, s_prdata;
  logic s_psel, s_penable, s_pwrite, s_pready, s_pslverr, busy;
  logic [AW-1:0] s_paddr;
  logic [3:0] s_pstrb;
  logic [2:0] s_pprot;
  logic [1:0] grant_idx;
  logic [31:0] addr [N];
  logic [31:0] wdata [N];
  logic wr [N];
  logic [3:0] strb [N];
  logic [2:0] prot [N];
  int n_vec = 0, n_bad = 0, hit, got, ptr_m, cur, nacc, last;
  bit act, done, found;
  logic [N-1:0] exp_rdy;
  logic [31:0] l_addr, l_wdata;
  logic l_wr;
  logic [3:0] l_strb;
  logic [2:0] l_prot;
  typedef struct {
    logic r; logic [2:0] sel; logic rdy; logic [31:0] rd;
    logic busy; logic pen; logic [2:0] mrdy; logic [31:0] mrd; logic [1:0] gnt; logic [31:0] addr;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      m_paddr[i*AW +: AW] = addr[i];
      m_pwdata[i*DW +: DW] = wdata[i];
      m_pstrb[i*4 +: 4] = strb[i];
      m_pprot[i*3 +: 3] = prot[i];
      m_pwrite[i] = wr[i];
    end
  assign m_penable = m_psel;

  apb_rr_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
    .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .busy(busy), .grant_idx(grant_idx));

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    m_psel = '0; s_pready = 0; s_prdata = '0; s_pslverr = 0;
    addr[0] = 32'h0200_BFF8; addr[1] = 32'h1000_0004; addr[2] = 32'h2000_0008;
    for (int i = 0; i < N; i++) begin wdata[i] = '0; wr[i] = 0; strb[i] = 4'hF; prot[i] = '0; end
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_spsel", s_psel, 0); chk("rst_spen", s_penable, 0);
    chk("rst_mrdy", m_pready, 0); chk("rst_merr", m_pslverr, 0); chk("rst_mrdata", m_prdata, 0);
    chk("rst_gnt", grant_idx, 0); chk("rst_saddr", s_paddr, 0); chk("rst_spwdata", s_pwdata, 0);
    step();
    tbl[0]  = '{0, 3'b001, 1, 32'h1234_5678, 0, 0, 3'b000, 0, 0, 0};
    tbl[1]  = '{0, 3'b001, 1, 32'h1234_5678, 1, 0, 3'b000, 0, 0, 32'h0200_BFF8};
    tbl[2]  = '{0, 3'b001, 1, 32'h1234_5678, 1, 1, 3'b001, 32'h1234_5678, 0, 32'h0200_BFF8};
    tbl[3]  = '{0, 3'b000, 1, 32'h1234_5678, 0, 0, 3'b000, 0, 0, 32'h0200_BFF8};
    tbl[4]  = '{1, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0200_BFF8};
    tbl[5]  = '{0, 3'b011, 1, 32'hAAAA_0000, 0, 0, 3'b000, 0, 0, 0};
    tbl[6]  = '{0, 3'b011, 1, 32'hAAAA_0000, 1, 0, 3'b000, 0, 0, 32'h0200_BFF8};
    tbl[7]  = '{0, 3'b011, 1, 32'hAAAA_0000, 1, 1, 3'b001, 32'hAAAA_0000, 0, 32'h0200_BFF8};
    tbl[8]  = '{0, 3'b010, 1, 32'hBBBB_1111, 0, 0, 3'b000, 0, 0, 32'h0200_BFF8};
    tbl[9]  = '{0, 3'b010, 1, 32'hBBBB_1111, 1, 0, 3'b000, 0, 1, 32'h1000_0004};
    tbl[10] = '{0, 3'b010, 1, 32'hBBBB_1111, 1, 1, 3'b010, 32'hBBBB_1111, 1, 32'h1000_0004};
    tbl[11] = '{0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 1, 32'h1000_0004};
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r; m_psel = tbl[i].sel; s_pready = tbl[i].rdy; s_prdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_spsel", i), s_psel, tbl[i].busy);
      chk($sformatf("tbl%0d_spen", i), s_penable, tbl[i].pen);
      chk($sformatf("tbl%0d_mrdy", i), m_pready, tbl[i].mrdy);
      chk($sformatf("tbl%0d_merr", i), m_pslverr, 0);
      chk($sformatf("tbl%0d_mrdata", i), m_prdata, tbl[i].mrd);
      chk($sformatf("tbl%0d_gnt", i), grant_idx, tbl[i].gnt);
      chk($sformatf("tbl%0d_saddr", i), s_paddr, tbl[i].addr);
      step();
    end
    rst = 0;
    // round-robin fairness with all three requesting continuously
    do_reset();
    m_psel = 3'b111; s_pready = 1;
    for (int k = 0; k < 9; k++) begin
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(negedge clk);
        if (m_pready != 0) begin
          got = 1;
          chk($sformatf("rr%0d_gnt", k), grant_idx, k % 3);
          chk($sformatf("rr%0d_mrdy", k), m_pready, 64'(1) << (k % 3));
        end
        step();
      end
      chk($sformatf("rr%0d_seen", k), got, 1);
    end
    m_psel = '0; s_pready = 0;
    // wait states followed by an error response
    wr[1] = 1; wdata[1] = 32'hDEAD_BEEF; strb[1] = 4'hF; m_psel = 3'b010;
    @(negedge clk);
    chk("ws_idle_busy", busy, 0);
    step();
    @(negedge clk);
    chk("ws_setup_gnt", grant_idx, 1); chk("ws_setup_pwrite", s_pwrite, 1);
    chk("ws_setup_pwdata", s_pwdata, 32'hDEAD_BEEF);
    wdata[1] = 32'h0BAD_0BAD;
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("ws_wait_spen", s_penable, 1); chk("ws_wait_pwdata", s_pwdata, 32'hDEAD_BEEF);
      chk("ws_wait_mrdy", m_pready, 0);
      step();
    end
    s_pready = 1; s_pslverr = 1;
    @(negedge clk);
    chk("ws_done_mrdy", m_pready, 3'b010); chk("ws_done_merr", m_pslverr, 3'b010);
    chk("ws_done_pstrb", s_pstrb, 4'hF); chk("ws_done_pwdata", s_pwdata, 32'hDEAD_BEEF);
    step();
    s_pready = 0; s_pslverr = 0; m_psel = '0;
    @(negedge clk);
    chk("ws_after_mrdy", m_pready, 0); chk("ws_after_merr", m_pslverr, 0); chk("ws_after_busy", busy, 0);
    step();
    wr[1] = 0; wdata[1] = '0;
    // watchdog on a completer that never answers
    m_psel = 3'b001; s_prdata = 32'hCAFE_F00D;
    step();
    step();
    hit = 0;
    for (int c = 1; c <= 20 && hit == 0; c++) begin
      @(negedge clk);
      if (m_pready != 0) begin
        hit = c;
        chk("wd_mrdy", m_pready, 3'b001); chk("wd_merr", m_pslverr, 3'b001);
        chk("wd_mrdata", m_prdata, 0);
      end else chk("wd_wait_merr", m_pslverr, 0);
      step();
    end
    chk("wd_cycles", hit, TO);
    m_psel = '0; s_pready = 1;
    @(negedge clk);
    chk("wd_late_mrdy", m_pready, 0); chk("wd_late_busy", busy, 0);
    step();
    m_psel = 3'b100; s_prdata = 32'h5555_AAAA;
    step();
    step();
    @(negedge clk);
    chk("wd_next_mrdy", m_pready, 3'b100); chk("wd_next_mrdata", m_prdata, 32'h5555_AAAA);
    chk("wd_next_gnt", grant_idx, 2);
    step();
    // reset asserted in ACCESS with m1 still waiting
    m_psel = 3'b011; s_pready = 0;
    step();
    step();
    rst = 1;
    @(negedge clk);
    chk("mr_rst_mrdy", m_pready, 0);
    step();
    rst = 0; m_psel = 3'b010;
    @(negedge clk);
    chk("mr_spsel", s_psel, 0); chk("mr_spen", s_penable, 0); chk("mr_mrdy", m_pready, 0);
    chk("mr_gnt", grant_idx, 0); chk("mr_busy", busy, 0);
    step();
    @(negedge clk);
    chk("mr_next_gnt", grant_idx, 1); chk("mr_next_saddr", s_paddr, 32'h1000_0004);
    step();
    s_pready = 1;
    @(negedge clk);
    chk("mr_next_mrdy", m_pready, 3'b010);
    step();
    m_psel = '0; s_pready = 0;
    // randomized traffic against a transaction-level reference
    do_reset();
    act = 0; ptr_m = 0; cur = 0; nacc = 0; last = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!m_psel[i] && $urandom_range(2) == 0) begin
          addr[i] = $urandom; wdata[i] = $urandom; wr[i] = 1'($urandom_range(1));
          strb[i] = 4'($urandom); prot[i] = 3'($urandom); m_psel[i] = 1;
        end
      s_pready = $urandom_range(3) != 0; s_prdata = $urandom; s_pslverr = $urandom_range(3) == 0;
      @(negedge clk);
      done = act && nacc > 0 && (s_pready || nacc == TO);
      exp_rdy = done ? N'(1) << cur : '0;
      chk("rnd_busy", busy, act); chk("rnd_spsel", s_psel, act);
      chk("rnd_spen", s_penable, act && nacc > 0);
      chk("rnd_mrdy", m_pready, exp_rdy);
      chk("rnd_merr", m_pslverr, done && (!s_pready || s_pslverr) ? exp_rdy : '0);
      chk("rnd_mrdata", m_prdata, done && s_pready ? s_prdata : '0);
      chk("rnd_gnt", grant_idx, last);
      if (act) begin
        chk("rnd_saddr", s_paddr, l_addr); chk("rnd_pwdata", s_pwdata, l_wdata);
        chk("rnd_pwrite", s_pwrite, l_wr); chk("rnd_pstrb", s_pstrb, l_strb);
        chk("rnd_pprot", s_pprot, l_prot);
      end
      if (!act) begin
        found = 0;
        for (int j = 0; j < N; j++)
          if (!found && m_psel[(ptr_m + j) % N]) begin cur = (ptr_m + j) % N; found = 1; end
        if (found) begin
          act = 1; nacc = 0; last = cur;
          l_addr = addr[cur]; l_wdata = wdata[cur]; l_wr = wr[cur]; l_strb = strb[cur]; l_prot = prot[cur];
        end
      end else if (done) begin
        act = 0; ptr_m = (cur + 1) % N;
      end else nacc++;
      step();
      if (done) m_psel[cur] = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
Round-robin arbiter that shares one APB4 completer port, such as the CLINT/PLIC or UART APB segment, between NUM_MST APB requesters, for example the AXI-to-APB bridge and a debug/DMA APB master. It serialises transfers through a SETUP/ACCESS sequencer, latches the winning request, and returns PRDATA/PSLVERR/PREADY only to the granted requester. An optional watchdog terminates hung completer accesses with an error.

Parameters:
NUM_MST, 2, number of requester ports (2..8)
ADDR_W, 32, PADDR width (`PADDR_SIZE)
DATA_W, 32, PWDATA/PRDATA width (`XLEN); PSTRB width = DATA_W/8
TIMEOUT, 0, cycles in ACCESS before forced error completion; 0 disables the watchdog

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
m_psel  in  NUM_MST  per-requester PSEL
m_penable  in  NUM_MST  per-requester PENABLE
m_pwrite  in  NUM_MST  per-requester PWRITE
m_paddr  in  NUM_MST*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
m_pwdata  in  NUM_MST*DATA_W  packed write data
m_pstrb  in  NUM_MST*DATA_W/8  packed strobes
m_pprot  in  NUM_MST*3  packed PPROT
m_prdata  out  DATA_W  read data, shared by all requesters, valid with the selected m_pready bit
m_pready  out  NUM_MST  per-requester PREADY
m_pslverr  out  NUM_MST  per-requester PSLVERR
s_psel, s_penable, s_pwrite  out  1 each  completer control
s_paddr  out  ADDR_W  completer address
s_pwdata  out  DATA_W  completer write data
s_pstrb  out  DATA_W/8  completer strobes
s_pprot  out  3  completer PPROT
s_prdata  in  DATA_W  completer read data
s_pready  in  1  completer PREADY
s_pslverr  in  1  completer PSLVERR
busy  out  1  state != IDLE
grant_idx  out  $clog2(NUM_MST) (min 1)  index of the current or last granted requester

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; ptr=0; grant_idx=0; all s_* outputs 0; m_pready=0; m_pslverr=0; m_prdata=0; busy=0; watchdog counter=0.
- Request: req[i] = m_psel[i]. PENABLE is ignored for arbitration, because a waiting requester sits in its access phase with PENABLE=1.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if req != 0, select the first set bit searching from ptr upward, wrapping modulo NUM_MST.
  - Latch the winner's pwrite, paddr, pwdata, pstrb and pprot, set grant_idx to the winner, and go to SETUP.
  - Otherwise remain in IDLE.
- SETUP: s_psel=1, s_penable=0, driving the latched fields. Go unconditionally to ACCESS.
- ACCESS: s_psel=1, s_penable=1.
  - When s_pready=1, drive m_pready[grant_idx]=1 combinationally in the same cycle, with m_prdata=s_prdata and m_pslverr[grant_idx]=s_pslverr.
  - Then set ptr = grant_idx+1 (mod NUM_MST) and go to IDLE.
- Response gating: m_pready, m_pslverr and m_prdata are 0 except in the completing ACCESS cycle, and only for grant_idx.
- Latency: a request first seen in IDLE at cycle T gives SETUP at T+1 and ACCESS at T+2. The earliest requester PREADY is T+2, for a zero-wait-state completer.
- Back-to-back: there is always one IDLE cycle between transfers. Requester throughput is therefore 1 transfer per 3 cycles minimum.
- Fairness: after any grant, the winner has lowest priority in the next arbitration. With k active requesters, each waits at most k-1 transfers.
- Watchdog (TIMEOUT>0):
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with s_pready=0.
  - When count == TIMEOUT-1 and s_pready is still 0, complete the requester with m_pready=1, m_pslverr=1 and m_prdata=0.
  - Then drop s_psel and go to IDLE. Any late completer response is ignored.
- Requester withdraws m_psel mid-transfer (protocol violation): the completer transfer still finishes normally and the response is discarded. The pointer still advances.
- Latched fields are stable for the whole SETUP+ACCESS regardless of requester input changes.
- Reset asserted in SETUP or ACCESS: s_psel and s_penable are 0 on the next edge, with no requester completion. The pointer returns to 0.
- Single requester (NUM_MST=1): behaves as a registering pipe stage with the same timing.

Test Plan:
- Single read, zero-wait completer:
  - Stimulus: m0 reads 0x0200_BFF8 at cycle 0; s_prdata=0x1234_5678; s_pready=1 in ACCESS.
  - Response: s_psel rises at cycle 1 and s_penable at cycle 2; m_pready[0]=1 with m_prdata=0x1234_5678 at cycle 2; busy=0 at cycle 3.
- Simultaneous requests after reset:
  - Stimulus: m0 and m1 both request at cycle 0; each transfer is zero-wait.
  - Response: grant order m0 then m1; m1 completes at cycle 5; m_pready[1] stays 0 until then.
- Round-robin fairness:
  - Stimulus: NUM_MST=3, all three request continuously for 9 transfers.
  - Response: grant_idx sequence is 0,1,2,0,1,2,0,1,2.
- Wait states and error:
  - Stimulus: m1 writes 0xDEADBEEF with pstrb=0xF; the completer holds s_pready low for 4 ACCESS cycles, then asserts it with s_pslverr=1.
  - Response: s_pwdata is stable throughout; m_pslverr[1]=1 with m_pready[1]=1 in exactly one cycle.
- Watchdog:
  - Stimulus: TIMEOUT=8; the completer never asserts s_pready.
  - Response: after 8 ACCESS cycles, m_pready[0]=1 and m_pslverr[0]=1; the FSM returns to IDLE and the next request is served normally.
- Mid-transfer reset:
  - Stimulus: assert rst during ACCESS.
  - Response: next cycle, s_psel=0, m_pready=0, grant_idx=0; after reset, a pending m1 request is granted.
